// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcode encodings, FSM states and the opcode -> ALU control mapping
// for the ALU command sequencer.
package alu_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [2:0] aluop;
        logic       cin;
        logic       legal;
        logic       is_mul;
    } op_ctrl_t;

    localparam logic [2:0] ALUOP_ADD = 3'b010;

    function automatic op_ctrl_t op_ctrl(input logic [2:0] op);
        op_ctrl_t c;
        c = '0;
        c.legal = 1'b1;
        case (op)
            OP_AND: c.aluop = 3'b000;
            OP_OR:  c.aluop = 3'b001;
            OP_ADD: c.aluop = ALUOP_ADD;
            OP_SUB: begin
                c.aluop = 3'b110;
                c.cin   = 1'b1;
            end
            OP_SLT: begin
                c.aluop = 3'b111;
                c.cin   = 1'b1;
            end
            // MUL is built from repeated ALU ADD passes
            OP_MUL: begin
                c.aluop  = ALUOP_ADD;
                c.is_mul = 1'b1;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response valid/ready channels of the ALU command sequencer.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_cout;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_err
    );
endinterface

// File: rtl/ALU_32Bit.sv
// Combinational ALU: aluop2 inverts B, {aluop1,aluop0} selects AND/OR/ADD/SLT;
// cout is always the adder carry.
module ALU_32Bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic             aluop0,
    input  logic             aluop1,
    input  logic             aluop2,
    input  logic             cin,
    output logic [WIDTH-1:0] outp,
    output logic             cout
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
    logic             less;

    assign b_eff        = aluop2 ? ~bi : bi;
    assign {carry, sum} = {1'b0, ai} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    // Signed less-than corrects the subtraction sign for overflow
    assign ovf  = (ai[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != ai[WIDTH-1]);
    assign less = sum[WIDTH-1] ^ ovf;
    assign cout = carry;

    always_comb begin
        case ({aluop1, aluop0})
            2'b00:   outp = ai & b_eff;
            2'b01:   outp = ai | b_eff;
            2'b10:   outp = sum;
            default: outp = {{(WIDTH-1){1'b0}}, less};
        endcase
    end
endmodule

// File: rtl/alu_cmd_sequencer_alu_op_decode.sv
// Combinational opcode decode into ALU control, legality and MUL flag.
module alu_op_decode
    import alu_cmd_sequencer_pkg::*;
(
    input  logic [2:0] op,
    output logic [2:0] aluop,
    output logic       cin,
    output logic       legal,
    output logic       is_mul
);
    op_ctrl_t ctrl;

    assign ctrl   = op_ctrl(op);
    assign aluop  = ctrl.aluop;
    assign cin    = ctrl.cin;
    assign legal  = ctrl.legal;
    assign is_mul = ctrl.is_mul;
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Sequences ALU operations from a command channel, including a shift-add MUL
// built from repeated ALU ADD passes, and returns results on a response channel.
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0] alu_ai,
    output logic [WIDTH-1:0] alu_bi,
    output logic             alu_aluop0,
    output logic             alu_aluop1,
    output logic             alu_aluop2,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_outp,
    input  logic             alu_cout
);
    localparam int CW = $clog2(MUL_ITERS + 1);

    state_e           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand_nx;
    logic [WIDTH-1:0] mplier_nx;

    logic [2:0] dec_aluop;
    logic       dec_cin;
    logic       dec_legal;
    logic       dec_is_mul;

    alu_op_decode u_dec (
        .op     (bus.cmd_op),
        .aluop  (dec_aluop),
        .cin    (dec_cin),
        .legal  (dec_legal),
        .is_mul (dec_is_mul)
    );

    assign mcand_nx  = mcand << 1;
    assign mplier_nx = mplier >> 1;

    // The accumulator lives in alu_ai: each MUL pass feeds alu_outp back as the next ai
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            bus.cmd_ready  <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_result <= '0;
            bus.rsp_cout   <= 1'b0;
            bus.rsp_err    <= 1'b0;
            alu_ai         <= '0;
            alu_bi         <= '0;
            {alu_aluop2, alu_aluop1, alu_aluop0} <= '0;
            alu_cin        <= 1'b0;
            mcand          <= '0;
            mplier         <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        if (!dec_legal) begin
                            bus.rsp_result <= '0;
                            bus.rsp_cout   <= 1'b0;
                            bus.rsp_err    <= 1'b1;
                            bus.rsp_valid  <= 1'b1;
                            state          <= ST_RESP;
                        end else if (dec_is_mul) begin
                            mcand   <= bus.cmd_a;
                            mplier  <= bus.cmd_b;
                            cnt     <= '0;
                            alu_ai  <= '0;
                            alu_bi  <= bus.cmd_b[0] ? bus.cmd_a : '0;
                            {alu_aluop2, alu_aluop1, alu_aluop0} <= ALUOP_ADD;
                            alu_cin <= 1'b0;
                            state   <= ST_MUL;
                        end else begin
                            alu_ai  <= bus.cmd_a;
                            alu_bi  <= bus.cmd_b;
                            {alu_aluop2, alu_aluop1, alu_aluop0} <= dec_aluop;
                            alu_cin <= dec_cin;
                            state   <= ST_EXEC;
                        end
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    bus.rsp_result <= alu_outp;
                    bus.rsp_cout   <= alu_cout;
                    bus.rsp_err    <= 1'b0;
                    bus.rsp_valid  <= 1'b1;
                    alu_ai         <= '0;
                    alu_bi         <= '0;
                    {alu_aluop2, alu_aluop1, alu_aluop0} <= '0;
                    alu_cin        <= 1'b0;
                    state          <= ST_RESP;
                end
                ST_MUL: begin
                    if (cnt == CW'(MUL_ITERS - 1)) begin
                        bus.rsp_result <= alu_outp;
                        bus.rsp_cout   <= 1'b0;
                        bus.rsp_err    <= 1'b0;
                        bus.rsp_valid  <= 1'b1;
                        alu_ai         <= '0;
                        alu_bi         <= '0;
                        {alu_aluop2, alu_aluop1, alu_aluop0} <= '0;
                        state          <= ST_RESP;
                    end else begin
                        alu_ai <= alu_outp;
                        alu_bi <= mplier_nx[0] ? mcand_nx : '0;
                        mcand  <= mcand_nx;
                        mplier <= mplier_nx;
                        cnt    <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized and directed bench for alu_cmd_sequencer driving ALU_32Bit,
// checked every cycle against a transaction-level arithmetic model.
module tb_alu_cmd_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] alu_ai, alu_bi, alu_outp;
    logic         alu_aluop0, alu_aluop1, alu_aluop2, alu_cin, alu_cout;

    int n_checks = 0;
    int n_fail   = 0;

    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

    alu_cmd_sequencer #(.WIDTH(W), .MUL_ITERS(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_ai     (alu_ai),
        .alu_bi     (alu_bi),
        .alu_aluop0 (alu_aluop0),
        .alu_aluop1 (alu_aluop1),
        .alu_aluop2 (alu_aluop2),
        .alu_cin    (alu_cin),
        .alu_outp   (alu_outp),
        .alu_cout   (alu_cout)
    );

    ALU_32Bit #(.WIDTH(W)) u_alu (
        .ai     (alu_ai),
        .bi     (alu_bi),
        .aluop0 (alu_aluop0),
        .aluop1 (alu_aluop1),
        .aluop2 (alu_aluop2),
        .cin    (alu_cin),
        .outp   (alu_outp),
        .cout   (alu_cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {aluop2,aluop1,aluop0,cin} the ALU must see while an op is executing
    function automatic logic [3:0] exp_ctl(input logic [2:0] op);
        case (op)
            3'b000:  return 4'b0000;
            3'b001:  return 4'b0010;
            3'b010:  return 4'b0100;
            3'b011:  return 4'b0100;
            3'b110:  return 4'b1101;
            3'b111:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op);
        if (op == 3'b100 || op == 3'b101) return 1;
        if (op == 3'b011) return W + 1;
        return 2;
    endfunction

    function automatic logic [31:0] mul_partial(input logic [31:0] a, input logic [31:0] b, input int k);
        logic [31:0] mask;
        logic [63:0] p;
        mask = (k >= 32) ? 32'hFFFF_FFFF : ((32'd1 << k) - 32'd1);
        p = {32'b0, a} * {32'b0, (b & mask)};
        return p[31:0];
    endfunction

    task automatic exp_rsp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic c, output logic e);
        logic [32:0] s;
        logic [63:0] p;
        s = {1'b0, a} + {1'b0, b};
        e = 1'b0;
        case (op)
            3'b000: begin r = a & b; c = s[32]; end
            3'b001: begin r = a | b; c = s[32]; end
            3'b010: begin r = s[31:0]; c = s[32]; end
            3'b110: begin r = a - b; c = (a >= b); end
            3'b111: begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; c = (a >= b); end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; c = 1'b0; end
            default: begin r = 32'd0; c = 1'b0; e = 1'b1; end
        endcase
    endtask

    // Model: ready/waiting/holding expressed as latency countdowns
    bit          m_ready = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait  = 0;
    int          m_k     = 0;
    logic [2:0]  m_op    = 3'b000;
    logic [31:0] m_a = '0, m_b = '0, m_res = '0;
    logic        m_cout = 1'b0, m_err = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e_ai, e_bi;
        logic [3:0]  e_ctl;
        if (rst) begin
            chk("rst_cmd_ready", bus.cmd_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_result", bus.rsp_result, 0);
            chk("rst_rsp_flags", {bus.rsp_cout, bus.rsp_err}, 0);
            chk("rst_alu_drive", {alu_ai, alu_bi, alu_aluop2, alu_aluop1, alu_aluop0, alu_cin}, 0);
            m_ready = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
            m_k     = 0;
        end else begin
            chk("cmd_ready", bus.cmd_ready, m_ready);
            chk("rsp_valid", bus.rsp_valid, m_valid);
            if (m_valid) begin
                chk("rsp_result", bus.rsp_result, m_res);
                chk("rsp_cout", bus.rsp_cout, m_cout);
                chk("rsp_err", bus.rsp_err, m_err);
            end
            e_ai = '0;
            e_bi = '0;
            e_ctl = '0;
            if (m_wait > 0) begin
                if (m_op == 3'b011) begin
                    e_ctl = 4'b0100;
                    e_ai  = mul_partial(m_a, m_b, m_k);
                    e_bi  = m_b[m_k] ? (m_a << m_k) : 32'd0;
                end else begin
                    e_ctl = exp_ctl(m_op);
                    e_ai  = m_a;
                    e_bi  = m_b;
                end
            end
            chk("alu_ctl", {alu_aluop2, alu_aluop1, alu_aluop0, alu_cin}, e_ctl);
            chk("alu_ai", alu_ai, e_ai);
            chk("alu_bi", alu_bi, e_bi);

            if (m_ready) begin
                if (bus.cmd_valid) begin
                    m_op = bus.cmd_op;
                    m_a  = bus.cmd_a;
                    m_b  = bus.cmd_b;
                    exp_rsp(m_op, m_a, m_b, m_res, m_cout, m_err);
                    m_ready = 1'b0;
                    m_wait  = exp_lat(m_op) - 1;
                    m_k     = 0;
                    m_valid = (m_wait == 0);
                end
            end else if (m_wait > 0) begin
                m_wait--;
                m_k++;
                if (m_wait == 0) m_valid = 1'b1;
            end else if (m_valid) begin
                if (bus.rsp_ready) begin
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                end
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input bit lit, input logic [31:0] lr,
                          input logic lc, input logic le);
        bit acc;
        bit got;
        int lat;
        @(posedge clk);
        #1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = (hold == 0);
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            return;
        end
        chk("rsp_latency", lat, exp_lat(op));
        if (lit) begin
            chk("lit_result", bus.rsp_result, lr);
            chk("lit_cout", bus.rsp_cout, lc);
            chk("lit_err", bus.rsp_err, le);
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            if (lit) chk("lit_result_held", bus.rsp_result, lr);
            @(posedge clk);
            #1 bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("cmd_ready_after_rsp", bus.cmd_ready, 1);
        chk("rsp_valid_after_rsp", bus.rsp_valid, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit got;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        repeat (2) @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_rsp_result", bus.rsp_result, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_release", bus.cmd_ready, 1);

        do_cmd(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        do_cmd(3'b110, 32'h0000_0000, 32'h0000_0001, 0, 1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_cmd(3'b111, 32'h0000_0000, 32'h0000_0001, 0, 1, 32'h0000_0001, 1'b0, 1'b0);
        do_cmd(3'b111, 32'h0000_0001, 32'h0000_0000, 1, 1, 32'h0000_0000, 1'b1, 1'b0);
        do_cmd(3'b011, 32'h0001_2345, 32'h0000_0100, 5, 1, 32'h0123_4500, 1'b0, 1'b0);
        do_cmd(3'b100, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1, 32'h0000_0000, 1'b0, 1'b1);
        do_cmd(3'b101, 32'h1234_5678, 32'h9ABC_DEF0, 2, 1, 32'h0000_0000, 1'b0, 1'b1);
        do_cmd(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 32'hF000_F000, 1'b1, 1'b0);
        do_cmd(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 32'hFFF0_FFF0, 1'b1, 1'b0);
        do_cmd(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 32'h0000_0001, 1'b0, 1'b0);

        // cmd_valid held through the response handshake must wait one extra cycle
        @(posedge clk);
        #1;
        bus.cmd_op    = 3'b010;
        bus.cmd_a     = 32'd5;
        bus.cmd_b     = 32'd7;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.cmd_op = 3'b001;
        bus.cmd_a  = 32'h0000_0003;
        bus.cmd_b  = 32'h0000_000C;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("chain_first_rsp_seen", got, 1);
        chk("chain_first_result", bus.rsp_result, 32'd12);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("chain_ready_after_hs", bus.cmd_ready, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("chain_second_rsp_seen", got, 1);
        chk("chain_second_result", bus.rsp_result, 32'h0000_000F);
        @(negedge clk);

        // Reset in the middle of a MUL aborts it without a response
        @(posedge clk);
        #1;
        bus.cmd_op    = 3'b011;
        bus.cmd_a     = 32'h0000_0123;
        bus.cmd_b     = 32'hFFFF_FFFF;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        chk("mulrst_accept", acc, 1);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mulrst_cmd_ready", bus.cmd_ready, 0);
        chk("mulrst_rsp_valid", bus.rsp_valid, 0);
        chk("mulrst_alu_ai", alu_ai, 0);
        chk("mulrst_alu_bi", alu_bi, 0);
        chk("mulrst_alu_ctl", {alu_aluop2, alu_aluop1, alu_aluop0, alu_cin}, 0);
        chk("mulrst_rsp_result", bus.rsp_result, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mulrst_ready_after_release", bus.cmd_ready, 1);
        repeat (3) @(negedge clk);
        chk("mulrst_no_rsp", bus.rsp_valid, 0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          hold;
            op   = 3'($urandom_range(0, 7));
            a    = pick();
            b    = pick();
            hold = $urandom_range(0, 3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_cmd(op, a, b, hold, 1'b0, 32'd0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command-side controller for the 32-bit combinational ALU. It accepts operation requests over a valid/ready interface and generates the ALU's aluop0/aluop1/aluop2/cin/ai/bi drive. It samples the ALU's outp/cout and returns results over a second valid/ready interface. It also builds a multi-cycle 32x32 multiply (low 32 bits) from repeated ALU ADD passes, so the datapath needs no separate multiplier.

Parameters:
WIDTH, 32, operand/result width; must match the ALU instance.
MUL_ITERS, WIDTH, add-shift iterations per MUL.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  operation code (see Behaviour)
cmd_a  in  WIDTH  operand A
cmd_b  in  WIDTH  operand B
alu_ai  out  WIDTH  to ALU ai
alu_bi  out  WIDTH  to ALU bi
alu_aluop0  out  1  to ALU aluop0
alu_aluop1  out  1  to ALU aluop1
alu_aluop2  out  1  to ALU aluop2
alu_cin  out  1  to ALU cin
alu_outp  in  WIDTH  from ALU result
alu_cout  in  1  from ALU carry-out
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_result  out  WIDTH  result word
rsp_cout  out  1  ALU carry-out of the final pass; 0 for MUL/illegal
rsp_err  out  1  illegal opcode flag

Behaviour:
- One clock domain. Reset is asynchronous and active-high: clk, rst. All registers clear immediately on rst.
- Reset values: cmd_ready=0 while rst is high and 1 in the first cycle after release. rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_err=0. alu_ai=alu_bi=0. All aluop and cin outputs are 0.
- Opcodes map directly onto ALU control {aluop2,aluop1,aluop0},cin:
  - 000 AND -> 000,0
  - 001 OR -> 001,0
  - 010 ADD -> 010,0
  - 110 SUB -> 110,1
  - 111 SLT -> 111,1
  - 011 MUL -> internal; the ALU runs ADD 010,0
  - 100 and 101 are illegal.
- ALU drive outputs are registered. The ALU is combinational, so alu_outp is sampled in the same cycle the drive is presented.
- FSM states: IDLE, EXEC, MUL, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, latch op, a and b, then:
    - legal non-MUL -> EXEC
    - MUL -> MUL, with acc=0, mcand=a, mplier=b, cnt=0
    - illegal -> RESP with result=0, err=1
  - EXEC: ALU drive = latched op, ai=a, bi=b. Capture rsp_result=alu_outp and rsp_cout=alu_cout, then go to RESP.
  - MUL: each cycle drive ADD with ai=acc, bi=(mplier[0] ? mcand : 0).
    - Update acc=alu_outp, mcand<<=1 (bits shifted out are lost), mplier>>=1, cnt++.
    - After MUL_ITERS passes go to RESP with result=acc and cout=0.
  - RESP: rsp_valid=1 and outputs held stable until rsp_ready. On the cycle rsp_valid&&rsp_ready, return to IDLE.
  - Outside EXEC and MUL, the ALU drive returns to all-zero.
- Latency from the accept edge to rsp_valid:
  - non-MUL: 2 cycles
  - illegal: 1 cycle
  - MUL: MUL_ITERS+1 cycles
- No new command is accepted while busy: cmd_ready=0 in EXEC, MUL and RESP.
- Response back-pressure: rsp_ready low holds RESP indefinitely. The result must not change while held.
- cmd_valid arriving in the same cycle rsp is accepted is not taken. It is accepted on the next cycle in IDLE, so throughput is at most one operation per 3 cycles.
- Reset mid-MUL or mid-RESP aborts the operation. No response is issued. The FSM restarts in IDLE.
- Overflow: MUL truncates to the low WIDTH bits. ADD/SUB wrap modulo 2^WIDTH, with the carry reported on rsp_cout.

Decomposition:
- Shared package: opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MUL), FSM state encoding, and the per-opcode ALU control mapping.
- One natural sub-module, alu_op_decode: combinational opcode -> {aluop2,aluop1,aluop0,cin,legal,is_mul}.
- The bench instantiates alu_cmd_sequencer with ALU_32Bit connected on its alu_* ports.

Test Plan:
- Reset mid-MUL: start MUL, assert rst at iteration 10 -> all outputs 0 immediately, no rsp_valid, cmd_ready=1 the cycle after release.
- ADD: a=0xFFFFFFFF, b=0xFFFFFFFF, rsp_ready=1 -> during EXEC alu_aluop={010} with cin=0; after 2 cycles rsp_result=0xFFFFFFFE, rsp_cout=1.
- SUB then SLT:
  - SUB a=0, b=1 -> result 0xFFFFFFFF, ALU drive {110},cin=1.
  - SLT a=0, b=1 -> result 0x00000001.
  - SLT a=1, b=0 -> result 0x00000000.
- MUL with back-pressure: a=0x00012345, b=0x00000100, rsp_ready=0 -> rsp_valid at cycle 33 with result 0x01234500, held unchanged for 5 cycles until rsp_ready=1, then cmd_ready=1 on the following cycle.
- Illegal op 100: a=0xDEADBEEF -> rsp_valid after 1 cycle, rsp_err=1, rsp_result=0, ALU drive stays all-zero.
- AND/OR sweep: a=0xF0F0F0F0, b=0xFF00FF00 -> AND gives 0xF000F000, OR gives 0xFFF0FFF0. cmd_ready=0 throughout each operation.
